playseq_jogador_automatico: RTL and testbench

- Autonomous player for the PlaySeq game, used for board self-test and regression.
- Sits on the game's outer interface, the opposite end from the game core:
  - it observes the game's leds/ganhou/perdeu outputs;
  - it drives the game's jogar/botoes inputs.
- Records each LED sequence the game presents, then replays it as button presses with fixed timing. Optionally it deliberately errs to exercise the losing path.

---
 rtl/playseq_auto_pkg.sv | 29 ++
 rtl/playseq_auto_buffer.sv | 63 ++++++
 rtl/playseq_jogador_automatico.sv | 150 +++++++++++++++
 tb/tb_playseq_jogador_automatico.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/playseq_auto_pkg.sv
// Shared definitions for the PlaySeq automatic player: state codes, default timings and
// small LED/button helpers.
package playseq_auto_pkg;

  typedef enum logic [3:0] {
    StOcioso    = 4'd0,
    StInicia    = 4'd1,
    StObserva   = 4'd2,
    StPressiona = 4'd3,
    StSolta     = 4'd4,
    StFim       = 4'd5
  } estado_e;

  localparam int unsigned ProfundidadePadrao = 16;
  localparam int unsigned SilencioPadrao     = 1000;
  localparam int unsigned PulsoPadrao        = 50;
  localparam int unsigned PausaPadrao        = 50;
  localparam int unsigned TimerW             = 16;

  function automatic logic eh_one_hot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Deliberate wrong press: the recorded button rotated left by one position.
  function automatic logic [3:0] rotl1(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

endpackage

// File: rtl/playseq_auto_buffer.sv
// Capture buffer for one LED presentation: saturating write count (which doubles as the
// write pointer), sticky overflow flag and a replay read pointer.
module playseq_auto_buffer
  import playseq_auto_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = ProfundidadePadrao,
  localparam int unsigned AW = $clog2(PROFUNDIDADE),
  localparam int unsigned CW = AW + 1
) (
  input  logic          i_clock,
  input  logic          i_reset,
  input  logic          i_limpa,
  input  logic          i_limpa_ovf,
  input  logic          i_escreve,
  input  logic [3:0]    i_dado,
  input  logic          i_avanca,
  output logic [3:0]    o_dado,
  output logic          o_ultimo,
  output logic          o_fim,
  output logic [CW-1:0] o_tamanho,
  output logic          o_overflow
);

  logic [3:0]    r_mem [PROFUNDIDADE];
  logic [CW-1:0] r_tam;
  logic [CW-1:0] r_rd;
  logic          r_ovf;
  logic          w_cheio;
  logic          w_grava;

  assign w_cheio = (r_tam == CW'(PROFUNDIDADE));
  assign w_grava = i_escreve && !w_cheio && !i_limpa;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_tam <= '0;
      r_rd  <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (i_limpa) begin
        r_tam <= '0;
        r_rd  <= '0;
      end else begin
        if (w_grava) r_tam <= r_tam + CW'(1);
        if (i_avanca) r_rd <= r_rd + CW'(1);
      end
      if (i_limpa_ovf) r_ovf <= 1'b0;
      else if (i_escreve && w_cheio) r_ovf <= 1'b1;
    end
  end

  // Storage needs no reset: only entries below r_tam are ever read back.
  always_ff @(posedge i_clock) begin
    if (w_grava) r_mem[r_tam[AW-1:0]] <= i_dado;
  end

  assign o_dado     = r_mem[r_rd[AW-1:0]];
  assign o_ultimo   = ((r_rd + CW'(1)) == r_tam);
  assign o_fim      = (r_rd == r_tam);
  assign o_tamanho  = r_tam;
  assign o_overflow = r_ovf;

endmodule

// File: rtl/playseq_jogador_automatico.sv
// Automatic PlaySeq player: records each LED presentation and replays it as timed button
// presses, optionally corrupting the last press of every replay.
module playseq_jogador_automatico
  import playseq_auto_pkg::*;
#(
  parameter int unsigned PROFUNDIDADE = ProfundidadePadrao,
  parameter int unsigned T_SILENCIO   = SilencioPadrao,
  parameter int unsigned T_PULSO      = PulsoPadrao,
  parameter int unsigned T_PAUSA      = PausaPadrao,
  localparam int unsigned TamW = $clog2(PROFUNDIDADE) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            iniciar,
  input  logic            errar,
  input  logic [3:0]      leds,
  input  logic            ganhou,
  input  logic            perdeu,
  output logic            jogar,
  output logic [3:0]      botoes,
  output logic            ativo,
  output logic            overflow,
  output logic [TamW-1:0] db_tamanho,
  output logic [3:0]      db_estado
);

  localparam logic [TimerW-1:0] LimSilencio = TimerW'(T_SILENCIO - 1);
  localparam logic [TimerW-1:0] LimPulso    = TimerW'(T_PULSO - 1);
  localparam logic [TimerW-1:0] LimPausa    = TimerW'(T_PAUSA - 1);

  estado_e           r_estado, w_estado_d;
  logic [TimerW-1:0] r_timer, w_timer_d;
  logic [3:0]        r_leds_q;
  logic [3:0]        r_botoes, w_botoes_d;
  logic              r_errar;

  logic              w_captura;
  logic              w_fim_jogo;
  logic              w_limpa;
  logic              w_limpa_ovf;
  logic              w_avanca;
  logic [3:0]        w_dado;
  logic [3:0]        w_tecla;
  logic              w_ultimo;
  logic              w_fim_buf;
  logic [TamW-1:0]   w_tamanho;
  logic              w_overflow;

  assign w_captura  = (r_estado == StObserva) && (r_leds_q == 4'd0) && eh_one_hot(leds);
  assign w_fim_jogo = ganhou || perdeu;
  assign w_tecla    = (r_errar && w_ultimo) ? rotl1(w_dado) : w_dado;

  playseq_auto_buffer #(
    .PROFUNDIDADE (PROFUNDIDADE)
  ) u_buffer (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_limpa     (w_limpa),
    .i_limpa_ovf (w_limpa_ovf),
    .i_escreve   (w_captura),
    .i_dado      (leds),
    .i_avanca    (w_avanca),
    .o_dado      (w_dado),
    .o_ultimo    (w_ultimo),
    .o_fim       (w_fim_buf),
    .o_tamanho   (w_tamanho),
    .o_overflow  (w_overflow)
  );

  always_comb begin
    w_estado_d  = r_estado;
    w_limpa     = 1'b0;
    w_limpa_ovf = 1'b0;
    w_avanca    = 1'b0;
    unique case (r_estado)
      StOcioso, StFim: begin
        if (iniciar) w_estado_d = StInicia;
      end
      StInicia: begin
        w_estado_d  = StObserva;
        w_limpa     = 1'b1;
        w_limpa_ovf = 1'b1;
      end
      StObserva: begin
        if (w_fim_jogo) w_estado_d = StFim;
        else if ((leds == 4'd0) && (r_timer >= LimSilencio) && (w_tamanho != '0))
          w_estado_d = StPressiona;
      end
      StPressiona: begin
        if (w_fim_jogo) w_estado_d = StFim;
        else if (r_timer >= LimPulso) begin
          // Advance on release so the next press can be registered straight from o_dado.
          w_estado_d = StSolta;
          w_avanca   = 1'b1;
        end
      end
      StSolta: begin
        if (w_fim_jogo) w_estado_d = StFim;
        else if (r_timer >= LimPausa) begin
          if (w_fim_buf) begin
            w_estado_d = StObserva;
            w_limpa    = 1'b1;
          end else begin
            w_estado_d = StPressiona;
          end
        end
      end
      default: w_estado_d = StOcioso;
    endcase
  end

  always_comb begin
    w_timer_d = '0;
    if (w_estado_d == r_estado) begin
      if (r_estado == StObserva) begin
        if (leds == 4'd0 && r_timer != '1) w_timer_d = r_timer + TimerW'(1);
        else if (leds == 4'd0) w_timer_d = r_timer;
      end else if (r_estado == StPressiona || r_estado == StSolta) begin
        w_timer_d = r_timer + TimerW'(1);
      end
    end
  end

  // Button drive follows the next state so it changes on the same edge as the state.
  assign w_botoes_d = (w_estado_d == StPressiona) ? w_tecla : 4'd0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado <= StOcioso;
      r_timer  <= '0;
      r_leds_q <= 4'd0;
      r_botoes <= 4'd0;
      r_errar  <= 1'b0;
    end else begin
      r_estado <= w_estado_d;
      r_timer  <= w_timer_d;
      r_leds_q <= leds;
      r_botoes <= w_botoes_d;
      if ((r_estado == StOcioso || r_estado == StFim) && iniciar) r_errar <= errar;
    end
  end

  assign jogar      = (r_estado == StInicia);
  assign botoes     = r_botoes;
  assign ativo      = (r_estado != StOcioso) && (r_estado != StFim);
  assign overflow   = w_overflow;
  assign db_tamanho = w_tamanho;
  assign db_estado  = r_estado;

endmodule

// File: tb/tb_playseq_jogador_automatico.sv
// Randomized self-checking bench for playseq_jogador_automatico against a queue-based
// model of the record/replay rules.
module tb_playseq_jogador_automatico;

  localparam int unsigned Prof = 16;
  localparam int unsigned TSil = 8;
  localparam int unsigned TPul = 3;
  localparam int unsigned TPau = 2;

  typedef logic [3:0] nib_q_t[$];

  logic       clock = 1'b0;
  logic       reset, iniciar, errar, ganhou, perdeu;
  logic [3:0] leds, botoes, db_estado;
  logic       jogar, ativo, overflow;
  logic [4:0] db_tamanho;

  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_err = 1'b0;
  logic exp_ovf = 1'b0;

  playseq_jogador_automatico #(
    .PROFUNDIDADE (Prof),
    .T_SILENCIO   (TSil),
    .T_PULSO      (TPul),
    .T_PAUSA      (TPau)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .iniciar    (iniciar),
    .errar      (errar),
    .leds       (leds),
    .ganhou     (ganhou),
    .perdeu     (perdeu),
    .jogar      (jogar),
    .botoes     (botoes),
    .ativo      (ativo),
    .overflow   (overflow),
    .db_tamanho (db_tamanho),
    .db_estado  (db_estado)
  );

  always #5 clock = ~clock;

  function automatic logic [3:0] errado(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic iniciar_jogo(input logic e);
    errar = e;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    errar = 1'b0;
    step();
    exp_err = e;
    exp_ovf = 1'b0;
  endtask

  task automatic present(input nib_q_t stim);
    foreach (stim[i]) begin
      leds = stim[i];
      step();
    end
    leds = 4'd0;
  endtask

  function automatic nib_q_t flashes(input nib_q_t vals, input int on_len, input int gap);
    nib_q_t s;
    foreach (vals[i]) begin
      repeat (on_len) s.push_back(vals[i]);
      if (i != vals.size() - 1) repeat (gap) s.push_back(4'd0);
    end
    return s;
  endfunction

  function automatic nib_q_t gen_round();
    nib_q_t s;
    int n = $urandom_range(1, 6);
    for (int i = 0; i < n; i++) begin
      logic [3:0] v;
      if (i != 0 && $urandom_range(0, 3) == 0) v = 4'($urandom_range(1, 15));
      else v = 4'b0001 << $urandom_range(0, 3);
      repeat ($urandom_range(1, 4)) s.push_back(v);
      if (i != n - 1) repeat ($urandom_range(1, TSil - 1)) s.push_back(4'd0);
    end
    return s;
  endfunction

  // Presents stim, then checks capture count, overflow and the full replay waveform.
  task automatic run_round(input string nome, input nib_q_t stim);
    nib_q_t     caps;
    nib_q_t     esp;
    logic [3:0] prev = 4'd0;
    foreach (stim[i]) begin
      if (prev == 4'd0 && $countones(stim[i]) == 1) caps.push_back(stim[i]);
      prev = stim[i];
    end
    if (caps.size() > Prof) exp_ovf = 1'b1;
    while (caps.size() > Prof) void'(caps.pop_back());
    repeat (TSil) esp.push_back(4'd0);
    foreach (caps[i]) begin
      logic [3:0] v = (exp_err && i == caps.size() - 1) ? errado(caps[i]) : caps[i];
      repeat (TPul) esp.push_back(v);
      repeat (TPau) esp.push_back(4'd0);
    end
    present(stim);
    for (int j = 0; j < esp.size(); j++) begin
      @(negedge clock);
      if (j == 0) begin
        n_tests++;
        if (db_tamanho !== 5'(caps.size())) begin
          n_fail++;
          $display("FAIL %s db_tamanho: got %0d expected %0d", nome, db_tamanho, caps.size());
        end
        n_tests++;
        if (overflow !== exp_ovf) begin
          n_fail++;
          $display("FAIL %s overflow: got %0b expected %0b", nome, overflow, exp_ovf);
        end
      end
      n_tests++;
      if (botoes !== esp[j]) begin
        n_fail++;
        $display("FAIL %s botoes[%0d]: got %b expected %b", nome, j, botoes, esp[j]);
      end
    end
    @(negedge clock);
    n_tests++;
    if (db_estado !== 4'd2 || db_tamanho !== 5'd0) begin
      n_fail++;
      $display("FAIL %s return: got estado=%0d tam=%0d expected estado=2 tam=0", nome,
               db_estado, db_tamanho);
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1; iniciar = 1'b0; errar = 1'b0; ganhou = 1'b0; perdeu = 1'b0; leds = 4'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_tests++;
    if ({jogar, botoes, ativo, overflow, db_tamanho, db_estado} !== 16'd0) begin
      n_fail++;
      $display("FAIL reset outputs: got jogar=%b botoes=%b ativo=%b ovf=%b tam=%0d est=%0d expected all 0",
               jogar, botoes, ativo, overflow, db_tamanho, db_estado);
    end
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic test_start();
    @(negedge clock);
    n_tests++;
    if (jogar !== 1'b0 || ativo !== 1'b0 || db_estado !== 4'd0) begin
      n_fail++;
      $display("FAIL idle: got jogar=%b ativo=%b est=%0d expected 0 0 0", jogar, ativo, db_estado);
    end
    step();
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
    @(negedge clock);
    n_tests++;
    if (jogar !== 1'b1 || db_estado !== 4'd1 || ativo !== 1'b1) begin
      n_fail++;
      $display("FAIL inicia: got jogar=%b est=%0d ativo=%b expected 1 1 1", jogar, db_estado, ativo);
    end
    step();
    @(negedge clock);
    n_tests++;
    if (jogar !== 1'b0 || db_estado !== 4'd2 || ativo !== 1'b1) begin
      n_fail++;
      $display("FAIL observa: got jogar=%b est=%0d ativo=%b expected 0 2 1", jogar, db_estado, ativo);
    end
    step();
    exp_err = 1'b0;
    exp_ovf = 1'b0;
  endtask

  task automatic test_replay();
    run_round("replay", flashes('{4'b0001, 4'b0100, 4'b1000}, 4, 4));
  endtask

  task automatic test_back_to_back();
    for (int r = 0; r < 3; r++) run_round($sformatf("random%0d", r), gen_round());
  endtask

  task automatic test_non_onehot();
    nib_q_t s;
    repeat (4) s.push_back(4'b0011);
    repeat (2) s.push_back(4'b0000);
    repeat (10) s.push_back(4'b0010);
    run_round("non_onehot", s);
  endtask

  task automatic test_overflow();
    nib_q_t v;
    for (int i = 0; i < 17; i++) v.push_back(4'b0001 << (i % 4));
    run_round("overflow", flashes(v, 1, 1));
  endtask

  task automatic test_ganhou();
    bit found = 1'b0;
    present(flashes('{4'b0001}, 2, 1));
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (botoes != 4'd0) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL ganhou wait: got no press expected press within 40 cycles");
    end
    ganhou = 1'b1;
    step();
    ganhou = 1'b0;
    @(negedge clock);
    n_tests++;
    if (botoes !== 4'd0 || db_estado !== 4'd5 || ativo !== 1'b0) begin
      n_fail++;
      $display("FAIL ganhou: got botoes=%b est=%0d ativo=%b expected 0000 5 0", botoes, db_estado, ativo);
    end
    step();
    iniciar_jogo(1'b1);
    @(negedge clock);
    n_tests++;
    if (overflow !== 1'b0 || db_estado !== 4'd2 || db_tamanho !== 5'd0) begin
      n_fail++;
      $display("FAIL restart: got ovf=%b est=%0d tam=%0d expected 0 2 0", overflow, db_estado, db_tamanho);
    end
    step();
  endtask

  task automatic test_errar();
    run_round("errar", flashes('{4'b0001, 4'b0100, 4'b1000}, 4, 4));
    run_round("errar_random", gen_round());
  endtask

  task automatic test_reset_solta();
    bit found = 1'b0;
    present(flashes('{4'b0100, 4'b0010}, 2, 1));
    for (int k = 0; k < 40; k++) begin
      @(negedge clock);
      if (db_estado == 4'd4) begin
        found = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL solta wait: got no SOLTA expected SOLTA within 40 cycles");
    end
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if ({jogar, botoes, ativo, overflow, db_tamanho, db_estado} !== 16'd0) begin
      n_fail++;
      $display("FAIL async reset: got jogar=%b botoes=%b ativo=%b ovf=%b tam=%0d est=%0d expected all 0",
               jogar, botoes, ativo, overflow, db_tamanho, db_estado);
    end
    step();
    reset = 1'b0;
    exp_ovf = 1'b0;
    @(negedge clock);
    n_tests++;
    if (db_estado !== 4'd0 || ativo !== 1'b0) begin
      n_fail++;
      $display("FAIL after reset: got est=%0d ativo=%b expected 0 0", db_estado, ativo);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_replay();
    test_back_to_back();
    test_non_onehot();
    test_overflow();
    test_ganhou();
    test_errar();
    test_reset_solta();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
